// File: rtl/collatz_arb.sv
`default_nettype none
// ============================================================================
// Module   : collatz_arb
// Purpose  : Two-requester round-robin front end sharing one iterative
//            Collatz datapath. A granted seed is iterated until it reaches 1
//            (result = number of steps) or an error condition is met
//            (seed 0, 3n+1 overflow, or step limit).
// Ports    : clk, nrst            - clock, asynchronous active-low reset
//            in0_valid/in0/in0_ready - requester 0 seed handshake
//            in1_valid/in1/in1_ready - requester 1 seed handshake
//            out_valid/out_ready     - result handshake
//            out0 / out_src / out_err - step count, source index, error flag
// Revision : 1.0 - initial release
// ============================================================================
module collatz_arb #(
    parameter int N         = 16,
    parameter int MAX_STEPS = 255
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         in0_valid,
    input  logic [N-1:0] in0,
    output logic         in0_ready,
    input  logic         in1_valid,
    input  logic [N-1:0] in1,
    output logic         in1_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out0,
    output logic         out_src,
    output logic         out_err
);

    localparam logic [N-1:0] STEP_LIMIT = N'(MAX_STEPS);
    localparam logic [N-1:0] ONE        = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           ptr;
    logic [N-1:0]   n;
    logic [N-1:0]   steps;
    logic           src;
    logic           grant0;
    logic           grant1;
    logic           finish;
    logic           finish_err;
    logic [N+1:0]   triple;
    logic           overflow;

    // 3n+1 computed two bits wider so that overflow past N bits is visible.
    assign triple   = {2'b00, n} + {1'b0, n, 1'b0} + {{(N+1){1'b0}}, 1'b1};
    assign overflow = |triple[N+1:N];

    // Exactly one grant in IDLE; on contention the pointer picks the winner.
    assign grant0 = (state == IDLE) && in0_valid && (!in1_valid || !ptr);
    assign grant1 = (state == IDLE) && in1_valid && (!in0_valid ||  ptr);

    // Ready is additionally forced low while reset is asserted.
    assign in0_ready = nrst & grant0;
    assign in1_ready = nrst & grant1;

    always_comb begin
        state_nxt  = state;
        finish     = 1'b0;
        finish_err = 1'b0;
        case (state)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (n == ONE) begin
                    finish = 1'b1;
                end else if (n == '0) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (steps == STEP_LIMIT) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (n[0] && overflow) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end
                if (finish) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr       <= 1'b0;
            n         <= '0;
            steps     <= '0;
            src       <= 1'b0;
            out_valid <= 1'b0;
            out0      <= '0;
            out_src   <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            // The result registers are captured on the RUN->DONE edge and
            // out_valid follows one edge later, giving a steps+2 latency.
            out_valid <= (state == DONE) && !(out_valid && out_ready);
            case (state)
                IDLE: begin
                    if (grant0) begin
                        n     <= in0;
                        steps <= '0;
                        src   <= 1'b0;
                        ptr   <= 1'b1;
                    end else if (grant1) begin
                        n     <= in1;
                        steps <= '0;
                        src   <= 1'b1;
                        ptr   <= 1'b0;
                    end
                end
                RUN: begin
                    if (finish) begin
                        out0    <= steps;
                        out_src <= src;
                        out_err <= finish_err;
                    end else begin
                        n     <= n[0] ? triple[N-1:0] : (n >> 1);
                        steps <= steps + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_collatz_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_collatz_arb
// Purpose  : Self-checking bench for collatz_arb: directed corner cases plus
//            randomized seeds/valid patterns against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_collatz_arb;

    localparam int N    = 16;
    localparam int MAXS = 255;
    localparam int LMAX = 100;

    logic         clk;
    logic         nrst;
    logic         in0_valid, in1_valid, in0_ready, in1_ready;
    logic [N-1:0] in0, in1, out0;
    logic         out_valid, out_ready, out_src, out_err;

    logic         l_in0_valid, l_in1_valid, l_in0_ready, l_in1_ready;
    logic [N-1:0] l_in0, l_in1, l_out0;
    logic         l_out_valid, l_out_ready, l_out_src, l_out_err;

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;

    collatz_arb #(.N(N), .MAX_STEPS(MAXS)) dut (
        .clk(clk), .nrst(nrst),
        .in0_valid(in0_valid), .in0(in0), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1(in1), .in1_ready(in1_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0(out0), .out_src(out_src), .out_err(out_err)
    );

    collatz_arb #(.N(N), .MAX_STEPS(LMAX)) dut_lim (
        .clk(clk), .nrst(nrst),
        .in0_valid(l_in0_valid), .in0(l_in0), .in0_ready(l_in0_ready),
        .in1_valid(l_in1_valid), .in1(l_in1), .in1_ready(l_in1_ready),
        .out_valid(l_out_valid), .out_ready(l_out_ready),
        .out0(l_out0), .out_src(l_out_src), .out_err(l_out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Collatz rules applied directly with plain integer arithmetic.
    function automatic void model(input int seed, input int maxs, output int st, output bit er);
        longint v;
        v  = seed;
        st = 0;
        er = 0;
        for (int k = 0; k < 100000; k++) begin
            if (v == 1) return;
            if (v == 0) begin er = 1; return; end
            if (st == maxs) begin er = 1; return; end
            if (v % 2 == 0) v = v / 2;
            else if (3 * v + 1 > (2 ** N) - 1) begin er = 1; return; end
            else v = 3 * v + 1;
            st++;
        end
    endfunction

    task automatic job(input bit v0, input bit v1, input logic [N-1:0] s0,
                       input logic [N-1:0] s1, input int hold, input bit keep);
        int  exp_src, est, edges;
        bit  eerr, stray;
        exp_src = (v0 && v1) ? ptr_m : (v0 ? 0 : 1);
        model(exp_src ? int'(s1) : int'(s0), MAXS, est, eerr);
        in0_valid = v0; in0 = s0;
        in1_valid = v1; in1 = s1;
        #1;
        check("grant0", in0_ready, (exp_src == 0) ? 1 : 0);
        check("grant1", in1_ready, (exp_src == 1) ? 1 : 0);
        tick();
        ptr_m = exp_src ? 0 : 1;
        if (!keep) begin in0_valid = 0; in1_valid = 0; end
        edges = 0;
        stray = 0;
        while (!out_valid && edges < 400) begin
            tick();
            edges++;
            if (in0_ready || in1_ready) stray = 1;
        end
        check("busy_ready", stray, 0);
        check("out_valid_seen", out_valid, 1);
        if (!eerr) check("latency", edges, est + 2);
        check("out0", out0, est);
        check("out_src", out_src, exp_src);
        check("out_err", out_err, eerr);
        if (hold > 0) begin
            out_ready = 0;
            if (!keep) begin
                in0_valid = 1; in1_valid = 1;
                in0 = N'($urandom); in1 = N'($urandom);
            end
            stray = 0;
            for (int h = 0; h < hold; h++) begin
                tick();
                if (!out_valid || out0 !== N'(est) || out_src !== exp_src[0] ||
                    out_err !== eerr || in0_ready || in1_ready) stray = 1;
            end
            check("hold_stable", stray, 0);
            if (!keep) begin in0_valid = 0; in1_valid = 0; end
            out_ready = 1;
        end
        tick();
        check("consumed", out_valid, 0);
    endtask

    initial begin
        int st, r;
        bit er;
        nrst = 0; out_ready = 1;
        in0_valid = 1; in1_valid = 1; in0 = 5; in1 = 9;
        l_in0_valid = 0; l_in1_valid = 0; l_in0 = 0; l_in1 = 0; l_out_ready = 1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_ready0", in0_ready, 0);
        check("rst_ready1", in1_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out0", out0, 0);
        check("rst_src", out_src, 0);
        check("rst_err", out_err, 0);
        in0_valid = 0; in1_valid = 0;
        @(negedge clk) nrst = 1;
        tick();

        job(1, 0, 27, 0, 0, 0);
        job(0, 1, 0, 1, 0, 0);
        job(1, 0, 0, 0, 0, 0);
        job(1, 0, 21845, 0, 0, 0);
        job(1, 0, 3, 0, 20, 0);

        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] a, b;
            r = $urandom_range(1, 3);
            a = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'($urandom_range(0, 200));
            b = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'($urandom_range(0, 200));
            job(r[0], r[1], a, b, $urandom_range(0, 3), 0);
        end

        // Arbitration from a fresh reset with both requesters held.
        @(negedge clk) nrst = 0;
        ptr_m = 0;
        @(negedge clk) nrst = 1;
        tick();
        job(1, 1, 6, 7, 0, 1);
        job(1, 1, 6, 7, 2, 1);
        job(1, 1, 6, 7, 0, 1);
        in0_valid = 0; in1_valid = 0;
        tick();

        // Reset in the middle of a long job discards it.
        in0_valid = 1; in0 = 27;
        tick();
        in0_valid = 0;
        repeat (50) tick();
        nrst = 0;
        in0_valid = 1; in1_valid = 1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_out0", out0, 0);
        check("mid_rst_ready", {in0_ready, in1_ready}, 0);
        in0_valid = 0; in1_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) nrst = 1;
        ptr_m = 0;
        #1;
        check("post_rst_valid", out_valid, 0);
        tick();
        job(1, 0, 6, 0, 0, 0);

        // Step-limit instance.
        model(27, LMAX, st, er);
        l_in0 = 27; l_in0_valid = 1;
        #1;
        check("lim_ready", l_in0_ready, 1);
        tick();
        l_in0_valid = 0;
        r = 0;
        while (!l_out_valid && r < 400) begin tick(); r++; end
        check("lim_valid", l_out_valid, 1);
        check("lim_out0", l_out0, st);
        check("lim_err", l_out_err, er);
        check("lim_src", l_out_src, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/collatz_arb.md
COLLATZ_ARB -- requirements
Module: collatz_arb

Interface
REQ-001 Parameter N, default 16: seed width, datapath width and step-count width (matches intN).
REQ-002 Parameter MAX_STEPS, default 255: step limit; reaching it without n==1 is an error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 in0_valid  input  1  requester 0 seed valid.
REQ-006 in0  input  N  requester 0 seed.
REQ-007 in0_ready  output  1  requester 0 seed accepted this cycle.
REQ-008 in1_valid  input  1  requester 1 seed valid.
REQ-009 in1  input  N  requester 1 seed.
REQ-010 in1_ready  output  1  requester 1 seed accepted this cycle.
REQ-011 out_valid  output  1  result held on out0/out_src/out_err.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 out0  output  N  step count.
REQ-014 out_src  output  1  index of requester that supplied the seed.
REQ-015 out_err  output  1  1 = seed 0, overflow or step limit.

Function
REQ-016 The block SHALL share one iterative Collatz datapath between two requesters; FSM states are IDLE, RUN and DONE.
REQ-017 Handshake rule: a transfer occurs on a rising edge where valid and ready are both 1; ready is combinational from state, valids and the priority pointer.
REQ-018 In IDLE, the block SHALL raise ready for exactly one requester with valid=1; if both are valid, the grant goes to the requester selected by the round-robin pointer.
REQ-019 The pointer SHALL reset to 0 and, after each grant, point to the requester that was not granted.
REQ-020 On acceptance, the block SHALL load n = seed, set steps = 0, record src, and enter RUN; in RUN and DONE both in*_ready SHALL be 0.
REQ-021 Each RUN cycle SHALL check, in priority order, and act on the first match:
  - n==1: enter DONE, err=0.
  - n==0: enter DONE, err=1.
  - steps==MAX_STEPS: enter DONE, err=1.
  - n even: n <= n>>1, steps+1.
  - n odd: compute 3n+1 at width N+2; if > 2^N-1, enter DONE with err=1 and steps unchanged; else n <= 3n+1, steps+1.
REQ-022 Latency SHALL be exact: out_valid rises (steps+2) rising edges after the acceptance edge, for error-free seeds.
REQ-023 In DONE, the block SHALL hold out_valid=1 with out0=steps, out_src and out_err stable until the edge where out_ready=1, then return to IDLE.
REQ-024 A new seed SHALL NOT be accepted on the same edge that the result is consumed; the earliest next acceptance is the following edge.
REQ-025 The block SHALL keep out_valid=0 outside DONE and SHALL never drop out_valid in DONE without out_ready.
REQ-026 Seed values held on in*_valid while the other requester is served SHALL be ignored until granted; there is no internal queue.

Reset
REQ-027 When nrst=0, the block SHALL immediately force the FSM to IDLE, pointer to 0, n and steps to 0, out_valid, out0, out_src and out_err to 0, and both in*_ready to 0 while nrst=0.
REQ-028 When nrst=0 during RUN or DONE, the block SHALL discard the in-flight job with no partial result emitted; after release, operation SHALL begin from IDLE.

Verification
REQ-029 Seed 27 on in0, out_ready=1 -> out0=111, out_src=0, out_err=0; out_valid rises exactly 113 edges after acceptance.
REQ-030 Seed 1 on in1 -> out0=0, out_src=1, out_err=0, 2 edges after acceptance; seed 0 -> out0=0, out_err=1.
REQ-031 After reset, in0=6 and in1=7 both valid and held -> in0 granted first (out0=8, out_src=0), then in1 (out0=16, out_src=1); with both still valid, the third grant goes to in0.
REQ-032 Seed 21845 (N=16) -> 3n+1=65536 overflows -> out_err=1, out0=0; instance MAX_STEPS=100 with seed 27 -> out_err=1, out0=100.
REQ-033 Seed 3, out_ready=0 for 20 cycles after out_valid -> out0=7, out_src and out_err stay stable and out_valid stays 1; both in*_ready stay 0 until the consume edge.
REQ-034 Seed 27, nrst pulsed low 50 cycles into RUN -> all outputs 0 immediately; after release, seed 6 -> out0=8 with no stale result.
